sp_ram_arbiter: RTL and testbench

//  Shares one sp_ram_wrap instance between two requesters using the req/gnt/rvalid protocol.
//  - Port 0 (m0) is the high-priority requester, e.g. core data port.
//  - Port 1 (m1) is the low-priority requester, e.g. debug or DMA.
//  - A starvation counter forces an m1 grant after MAX_STALL consecutive denials.
//  - Sits between the bus adapters and sp_ram_wrap. The RAM read latency is 1 cycle.

---
 rtl/sp_ram_arbiter.sv | 95 +++++++++
 tb/tb_sp_ram_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_arbiter.sv
// Two-port fixed-priority arbiter onto one single-port RAM, m0 preferred, m1 forced after MAX_STALL denials.
// Grant is combinational (same-cycle accept); rvalid follows 1 cycle later; a denied requester holds req.
module sp_ram_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_STALL  = 4
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = $clog2(MAX_STALL + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [BW-1:0]         be;
    logic [DATA_WIDTH-1:0] wdata;
  } ram_cmd_t;

  logic [CW-1:0] stall_cnt;
  logic          force_m1;
  logic          rv_q;
  logic          owner_q;
  ram_cmd_t      cmd;

  assign force_m1 = (stall_cnt == CW'(MAX_STALL));
  assign m1_gnt_o = m1_req_i & (~m0_req_i | force_m1);
  assign m0_gnt_o = m0_req_i & ~m1_gnt_o;
  assign ram_en_o = m0_gnt_o | m1_gnt_o;

  // Idle cycles drive zeros so the RAM pins never see stale payload.
  always_comb begin
    cmd = '0;
    if (m0_gnt_o) begin
      cmd = '{addr: m0_addr_i, we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
    end else if (m1_gnt_o) begin
      cmd = '{addr: m1_addr_i, we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};
    end
  end

  assign ram_addr_o  = cmd.addr;
  assign ram_we_o    = cmd.we;
  assign ram_be_o    = cmd.be;
  assign ram_wdata_o = cmd.wdata;

  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      rv_q      <= 1'b0;
      owner_q   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      rv_q <= ram_en_o;
      if (ram_en_o) begin
        owner_q <= m1_gnt_o;
      end
      if (m1_req_i && !m1_gnt_o) begin
        if (!force_m1) begin
          stall_cnt <= stall_cnt + CW'(1);
        end
      end else begin
        stall_cnt <= '0;
      end
    end
  end

  assign m0_rvalid_o = rv_q & ~owner_q;
  assign m1_rvalid_o = rv_q & owner_q;
  assign m0_rdata_o  = ram_rdata_i;
  assign m1_rdata_o  = ram_rdata_i;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter with a behavioural 1-cycle-latency RAM behind it.
module tb_sp_ram_arbiter;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rstn_i;
  logic          m0_req_i, m1_req_i;
  logic          m0_gnt_o, m1_gnt_o;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic          m0_we_i, m1_we_i;
  logic [BW-1:0] m0_be_i, m1_be_i;
  logic [DW-1:0] m0_wdata_i, m1_wdata_i;
  logic          m0_rvalid_o, m1_rvalid_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic          ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [BW-1:0] ram_be_o;
  logic [DW-1:0] ram_wdata_o;
  logic [DW-1:0] ram_rdata_i;

  logic [DW-1:0] mem [0:255];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_STALL(4)) dut (
    .clk(clk), .rstn_i(rstn_i),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  // Behavioural single-port RAM: write with byte enables, read data one cycle later.
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < BW; b++) begin
          if (ram_be_o[b]) mem[ram_addr_o[9:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
        end
      end else begin
        ram_rdata_i <= mem[ram_addr_o[9:2]];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_be_i = '0; m0_wdata_i = '0;
    m1_req_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_be_i = '0; m1_wdata_i = '0;
  endtask

  task automatic test_reset();
    idle();
    rstn_i = 0;
    step();
    step();
    total++; if (m0_gnt_o !== 1'b0 || m1_gnt_o !== 1'b0) begin bad++; $display("FAIL rst_gnt: got %b%b want 00", m0_gnt_o, m1_gnt_o); end
    total++; if (m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got %b%b want 00", m0_rvalid_o, m1_rvalid_o); end
    total++; if (ram_en_o !== 1'b0) begin bad++; $display("FAIL rst_ram_en: got %b want 0", ram_en_o); end
    total++; if (dut.stall_cnt !== 3'd0) begin bad++; $display("FAIL rst_stall: got %0d want 0", dut.stall_cnt); end
    rstn_i = 1;
    step();
  endtask

  task automatic test_m0_write_read();
    m0_req_i = 1; m0_we_i = 1; m0_addr_i = 15'h10; m0_be_i = 4'hF; m0_wdata_i = 32'hDEADBEEF;
    #1;
    total++; if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0) begin bad++; $display("FAIL wr_gnt: got %b%b want 10", m0_gnt_o, m1_gnt_o); end
    total++; if (ram_en_o !== 1'b1 || ram_we_o !== 1'b1 || ram_addr_o !== 15'h10 || ram_wdata_o !== 32'hDEADBEEF || ram_be_o !== 4'hF)
      begin bad++; $display("FAIL wr_ram: got en=%b we=%b a=%h d=%h be=%h want 1 1 0010 deadbeef f", ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o); end
    step();
    total++; if (m0_rvalid_o !== 1'b1 || m1_rvalid_o !== 1'b0) begin bad++; $display("FAIL wr_rvalid: got %b%b want 10", m0_rvalid_o, m1_rvalid_o); end
    m0_we_i = 0; m0_wdata_i = '0;
    #1;
    total++; if (m0_gnt_o !== 1'b1 || ram_we_o !== 1'b0) begin bad++; $display("FAIL rd_gnt: got gnt=%b we=%b want 1 0", m0_gnt_o, ram_we_o); end
    step();
    total++; if (m0_rvalid_o !== 1'b1 || m1_rvalid_o !== 1'b0) begin bad++; $display("FAIL rd_rvalid: got %b%b want 10", m0_rvalid_o, m1_rvalid_o); end
    total++; if (m0_rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", m0_rdata_o); end
    idle();
    step();
    total++; if (m0_rvalid_o !== 1'b0) begin bad++; $display("FAIL rd_rvalid_drop: got %b want 0", m0_rvalid_o); end
  endtask

  task automatic test_starvation();
    logic prev_m1;
    prev_m1 = 0;
    m0_req_i = 1; m0_addr_i = 15'h10;
    m1_req_i = 1; m1_addr_i = 15'h10;
    for (int k = 0; k < 10; k++) begin
      #1;
      total++; if (m1_gnt_o !== (k % 5 == 4) || m0_gnt_o !== (k % 5 != 4))
        begin bad++; $display("FAIL starve_gnt[%0d]: got %b%b want %b%b", k, m0_gnt_o, m1_gnt_o, k % 5 != 4, k % 5 == 4); end
      total++; if (dut.stall_cnt !== 3'(k % 5)) begin bad++; $display("FAIL starve_cnt[%0d]: got %0d want %0d", k, dut.stall_cnt, k % 5); end
      if (k > 0) begin
        total++; if (m1_rvalid_o !== prev_m1 || m0_rvalid_o !== !prev_m1)
          begin bad++; $display("FAIL starve_rvalid[%0d]: got %b%b want %b%b", k, m0_rvalid_o, m1_rvalid_o, !prev_m1, prev_m1); end
      end
      prev_m1 = (k % 5 == 4);
      step();
    end
    idle();
    total++; if (m1_rvalid_o !== 1'b1 || m0_rvalid_o !== 1'b0) begin bad++; $display("FAIL starve_last_rvalid: got %b%b want 01", m0_rvalid_o, m1_rvalid_o); end
    step();
  endtask

  task automatic test_stall_clear();
    m1_req_i = 1; m1_addr_i = 15'h10;
    #1;
    total++; if (m1_gnt_o !== 1'b1 || ram_addr_o !== 15'h10) begin bad++; $display("FAIL m1_alone_gnt: got gnt=%b a=%h want 1 0010", m1_gnt_o, ram_addr_o); end
    step();
    total++; if (m1_rvalid_o !== 1'b1 || m1_rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL m1_alone_rsp: got v=%b d=%h want 1 deadbeef", m1_rvalid_o, m1_rdata_o); end
    m0_req_i = 1; m0_addr_i = 15'h10;
    step();
    step();
    total++; if (dut.stall_cnt !== 3'd2) begin bad++; $display("FAIL clr_cnt2: got %0d want 2", dut.stall_cnt); end
    m1_req_i = 0;
    step();
    total++; if (dut.stall_cnt !== 3'd0) begin bad++; $display("FAIL clr_cnt0: got %0d want 0", dut.stall_cnt); end
    m1_req_i = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (m1_gnt_o !== (k == 4)) begin bad++; $display("FAIL clr_regnt[%0d]: got %b want %b", k, m1_gnt_o, k == 4); end
      step();
    end
    idle();
    step();
  endtask

  task automatic test_alternate();
    logic [DW-1:0] pat [0:2];
    pat[0] = 32'h11111111; pat[1] = 32'h22222222; pat[2] = 32'h33333333;
    m0_req_i = 1; m0_we_i = 1; m0_be_i = 4'hF;
    for (int i = 0; i < 3; i++) begin
      m0_addr_i = 15'(4 * i); m0_wdata_i = pat[i];
      step();
      total++; if (m0_rvalid_o !== 1'b1) begin bad++; $display("FAIL preload_rvalid[%0d]: got %b want 1", i, m0_rvalid_o); end
    end
    idle();
    m0_req_i = 1; m0_addr_i = 15'h0;
    step();
    m0_req_i = 0; m1_req_i = 1; m1_addr_i = 15'h4;
    total++; if (m0_rvalid_o !== 1'b1 || m1_rvalid_o !== 1'b0 || m0_rdata_o !== pat[0])
      begin bad++; $display("FAIL alt_a: got v=%b%b d=%h want 10 %h", m0_rvalid_o, m1_rvalid_o, m0_rdata_o, pat[0]); end
    step();
    m1_req_i = 0; m0_req_i = 1; m0_addr_i = 15'h8;
    total++; if (m1_rvalid_o !== 1'b1 || m0_rvalid_o !== 1'b0 || m1_rdata_o !== pat[1])
      begin bad++; $display("FAIL alt_b: got v=%b%b d=%h want 01 %h", m0_rvalid_o, m1_rvalid_o, m1_rdata_o, pat[1]); end
    step();
    idle();
    total++; if (m0_rvalid_o !== 1'b1 || m1_rvalid_o !== 1'b0 || m0_rdata_o !== pat[2])
      begin bad++; $display("FAIL alt_c: got v=%b%b d=%h want 10 %h", m0_rvalid_o, m1_rvalid_o, m0_rdata_o, pat[2]); end
    step();
  endtask

  task automatic test_reset_after_grant();
    m0_req_i = 1; m0_addr_i = 15'h10;
    m1_req_i = 1; m1_addr_i = 15'h4;
    step();
    step();
    total++; if (dut.stall_cnt !== 3'd2) begin bad++; $display("FAIL rag_cnt2: got %0d want 2", dut.stall_cnt); end
    m0_req_i = 0;
    #1;
    total++; if (m1_gnt_o !== 1'b1) begin bad++; $display("FAIL rag_gnt: got %b want 1", m1_gnt_o); end
    rstn_i = 0;
    step();
    total++; if (m1_rvalid_o !== 1'b0 || m0_rvalid_o !== 1'b0) begin bad++; $display("FAIL rag_rvalid: got %b%b want 00", m0_rvalid_o, m1_rvalid_o); end
    total++; if (dut.stall_cnt !== 3'd0) begin bad++; $display("FAIL rag_cnt0: got %0d want 0", dut.stall_cnt); end
    m1_req_i = 0; m0_req_i = 1;
    #1;
    total++; if (m0_gnt_o !== 1'b1 || ram_en_o !== 1'b1) begin bad++; $display("FAIL rag_gnt_in_rst: got gnt=%b en=%b want 1 1", m0_gnt_o, ram_en_o); end
    step();
    total++; if (m0_rvalid_o !== 1'b0) begin bad++; $display("FAIL rag_rvalid_in_rst: got %b want 0", m0_rvalid_o); end
    rstn_i = 1;
    step();
    idle();
    total++; if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL rag_resume: got v=%b d=%h want 1 deadbeef", m0_rvalid_o, m0_rdata_o); end
    step();
  endtask

  initial begin
    idle();
    rstn_i = 0;
    test_reset();
    test_m0_write_read();
    test_starvation();
    test_stall_clear();
    test_alternate();
    test_reset_after_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
